division_launcher: RTL and testbench

Handshake front/back-end for the iterative divider core. Accepts one dividend/divisor pair per valid/ready transaction and registers it toward the core. It then issues a one-cycle start pulse and waits for the core's completion. Once the core finishes, it captures quotient and remainder and presents them downstream on a second valid/ready port. Sits directly around the divider: it feeds the core's start/operand inputs and consumes its ready/quotient/remainder outputs.

---
 rtl/division_launcher_if.sv | 42 ++++
 rtl/division_launcher.sv | 133 +++++++++++++
 tb/tb_division_launcher.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/division_launcher_if.sv
// Operand, divider-core and result signals of the division launcher, bundled for one port.
// slave is the launcher's view; master is the upstream/core/downstream view.
interface division_launcher_if #(
  parameter int DW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [DW-1:0] in_divisor;

  logic          div_start;
  logic [DW-1:0] div_dividend;
  logic [DW-1:0] div_divisor;
  logic          div_ready;
  logic [DW-1:0] div_quotient;
  logic [DW-1:0] div_remainder;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quotient;
  logic [DW-1:0] out_remainder;
  logic          out_dbz;
  logic          out_timeout;

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    output in_ready,
    output div_start, div_dividend, div_divisor,
    input  div_ready, div_quotient, div_remainder,
    output out_valid, out_quotient, out_remainder, out_dbz, out_timeout,
    input  out_ready
  );

  modport master (
    output in_valid, in_dividend, in_divisor,
    input  in_ready,
    input  div_start, div_dividend, div_divisor,
    output div_ready, div_quotient, div_remainder,
    input  out_valid, out_quotient, out_remainder, out_dbz, out_timeout,
    output out_ready
  );
endinterface

// File: rtl/division_launcher.sv
// Valid/ready wrapper around the iterative divider: 2 cycles plus core latency; result held until out_ready.
// Define DIVISION_LAUNCHER_DBZ_EN to answer zero divisors locally (quotient all ones, dbz flag) without starting the core.
module division_launcher #(
  parameter int DW         = 4,
  parameter int MAX_CYCLES = 2*DW+4
) (
  input  logic              clk,
  input  logic              rst,
  division_launcher_if.slave bus
);

  localparam int CW = $clog2(MAX_CYCLES+1);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wd_cnt;
  logic          seen_low;
  logic [DW-1:0] dividend_q;
  logic [DW-1:0] divisor_q;
  logic [DW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;
  logic          timeout_q;
  logic          accept;
  logic          done;
  logic          expire;
  logic          zero_div;
  logic          in_ready_c;
  logic          div_start_c;
  logic          out_valid_c;

  assign accept = bus.in_valid & in_ready_c;
  // seen_low guards against a ready level left over from the previous operation
  assign done   = (state == BUSY) & bus.div_ready & seen_low;
  assign expire = (state == BUSY) & ~done & (wd_cnt == CW'(MAX_CYCLES-1));

`ifdef DIVISION_LAUNCHER_DBZ_EN
  logic dbz_q;
  assign zero_div    = (bus.in_divisor == '0);
  assign bus.out_dbz = dbz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dbz_q <= 1'b0;
    else if (accept)
      dbz_q <= zero_div;
  end
`else
  assign zero_div    = 1'b0;
  assign bus.out_dbz = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_div ? HOLD : LAUNCH;
      LAUNCH:  state_nxt = BUSY;
      BUSY:    if (done || expire) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    div_start_c = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE:    in_ready_c  = 1'b1;
      LAUNCH:  div_start_c = 1'b1;
      HOLD:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      timeout_q   <= 1'b0;
      wd_cnt      <= '0;
      seen_low    <= 1'b0;
    end else begin
      if (accept) begin
        dividend_q <= bus.in_dividend;
        divisor_q  <= bus.in_divisor;
        timeout_q  <= 1'b0;
        if (zero_div) begin
          quotient_q  <= '1;
          remainder_q <= bus.in_dividend;
        end
      end
      if (state == LAUNCH) begin
        wd_cnt   <= '0;
        seen_low <= 1'b0;
      end
      if (state == BUSY) begin
        wd_cnt <= wd_cnt + CW'(1);
        if (!bus.div_ready)
          seen_low <= 1'b1;
        // completion takes priority over a watchdog expiring on the same edge
        if (done) begin
          quotient_q  <= bus.div_quotient;
          remainder_q <= bus.div_remainder;
        end else if (expire) begin
          quotient_q  <= '0;
          remainder_q <= '0;
          timeout_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.div_start     = div_start_c;
  assign bus.div_dividend  = dividend_q;
  assign bus.div_divisor   = divisor_q;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_quotient  = quotient_q;
  assign bus.out_remainder = remainder_q;
  assign bus.out_timeout   = timeout_q;

endmodule

// File: tb/tb_division_launcher.sv
// Directed bench for division_launcher with a cycle-accurate divider core model.
module tb_division_launcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  division_launcher_if #(.DW(4)) bus ();

  division_launcher #(.DW(4), .MAX_CYCLES(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int starts_seen = 0;

  // Divider core model: ready drops the edge after start, returns m_lat edges after the start edge.
  logic       m_ready;
  logic [3:0] m_q, m_r, m_a, m_b;
  int         m_cnt;
  int         m_lat   = 3;
  bit         m_stuck = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_q     <= 4'd0;
      m_r     <= 4'd0;
      m_a     <= 4'd0;
      m_b     <= 4'd0;
      m_cnt   <= 0;
    end else if (!m_stuck) begin
      if (bus.div_start) begin
        m_ready <= 1'b0;
        m_cnt   <= m_lat;
        m_a     <= bus.div_dividend;
        m_b     <= bus.div_divisor;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ready <= 1'b1;
          m_q     <= (m_b == 0) ? 4'hF : m_a / m_b;
          m_r     <= (m_b == 0) ? m_a : m_a % m_b;
        end
      end
    end
  end

  assign bus.div_ready     = m_ready;
  assign bus.div_quotient  = m_q;
  assign bus.div_remainder = m_r;

  always @(posedge clk) if (bus.div_start === 1'b1) starts_seen++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench hung");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a pair and returns just after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    tick;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      tick;
      n++;
    end
  endtask

  task automatic consume;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    total++;
    if ({bus.in_ready, bus.div_start, bus.out_valid, bus.out_dbz, bus.out_timeout} !== 5'b10000) begin
      bad++;
      $display("FAIL reset_ctrl: rdy/start/vld/dbz/to=%b required 10000",
               {bus.in_ready, bus.div_start, bus.out_valid, bus.out_dbz, bus.out_timeout});
    end
    total++;
    if ({bus.div_dividend, bus.div_divisor, bus.out_quotient, bus.out_remainder} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_data: dd/dv/q/r=%h required 0000",
               {bus.div_dividend, bus.div_divisor, bus.out_quotient, bus.out_remainder});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    int n;
    int s0 = starts_seen;
    send(4'd15, 4'd3);
    total++;
    if (bus.div_start !== 1'b1 || bus.div_dividend !== 4'd15 || bus.div_divisor !== 4'd3) begin
      bad++;
      $display("FAIL basic_launch: start=%b dd=%0d dv=%0d required 1 15 3",
               bus.div_start, bus.div_dividend, bus.div_divisor);
    end
    wait_valid(40, n);
    total++;
    if (n !== 5) begin
      bad++;
      $display("FAIL basic_latency: %0d cycles required 5", n);
    end
    total++;
    if (bus.out_quotient !== 4'd5 || bus.out_remainder !== 4'd0 || bus.out_dbz !== 1'b0 || bus.out_timeout !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b to=%b required 5 0 0 0",
               bus.out_quotient, bus.out_remainder, bus.out_dbz, bus.out_timeout);
    end
    total++;
    if (starts_seen - s0 !== 1) begin
      bad++;
      $display("FAIL basic_starts: %0d pulses required 1", starts_seen - s0);
    end
    consume;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_consume: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    int n;
    send(4'd13, 4'd4);
    wait_valid(40, n);
    bus.in_valid    = 1'b1;
    bus.in_dividend = 4'd7;
    bus.in_divisor  = 4'd2;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_quotient !== 4'd3 || bus.out_remainder !== 4'd1 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: vld=%b q=%0d r=%0d in_ready=%b required 1 3 1 0",
                 i, bus.out_valid, bus.out_quotient, bus.out_remainder, bus.in_ready);
      end
      tick;
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.div_start !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b vld=%b start=%b required 1 0 0",
               bus.in_ready, bus.out_valid, bus.div_start);
    end
    tick;
    bus.in_valid = 1'b0;
    total++;
    if (bus.div_start !== 1'b1 || bus.div_dividend !== 4'd7 || bus.div_divisor !== 4'd2) begin
      bad++;
      $display("FAIL bp_next_accept: start=%b dd=%0d dv=%0d required 1 7 2",
               bus.div_start, bus.div_dividend, bus.div_divisor);
    end
    wait_valid(40, n);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_quotient !== 4'd3 || bus.out_remainder !== 4'd1) begin
      bad++;
      $display("FAIL bp_second: vld=%b q=%0d r=%0d required 1 3 1", bus.out_valid, bus.out_quotient, bus.out_remainder);
    end
    consume;
  endtask

  task automatic test_timeout;
    int n;
    m_stuck = 1;
    send(4'd5, 4'd1);
    wait_valid(40, n);
    total++;
    if (n !== 13) begin
      bad++;
      $display("FAIL timeout_latency: %0d cycles required 13", n);
    end
    total++;
    if (bus.out_timeout !== 1'b1 || bus.out_quotient !== 4'd0 || bus.out_remainder !== 4'd0 || bus.out_dbz !== 1'b0) begin
      bad++;
      $display("FAIL timeout_result: to=%b q=%0d r=%0d dbz=%b required 1 0 0 0",
               bus.out_timeout, bus.out_quotient, bus.out_remainder, bus.out_dbz);
    end
    consume;
    m_stuck = 0;
  endtask

  task automatic test_done_vs_watchdog;
    int n;
    m_lat = 11;
    send(4'd14, 4'd4);
    wait_valid(40, n);
    total++;
    if (n !== 13 || bus.out_timeout !== 1'b0 || bus.out_quotient !== 4'd3 || bus.out_remainder !== 4'd2) begin
      bad++;
      $display("FAIL done_wins: n=%0d to=%b q=%0d r=%0d required 13 0 3 2",
               n, bus.out_timeout, bus.out_quotient, bus.out_remainder);
    end
    consume;
    m_lat = 3;
  endtask

  task automatic test_dbz;
    int n;
    int s0 = starts_seen;
    send(4'd9, 4'd0);
`ifdef DIVISION_LAUNCHER_DBZ_EN
    total++;
    if (bus.div_start !== 1'b0 || bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL dbz_direct: start=%b vld=%b required 0 1", bus.div_start, bus.out_valid);
    end
    total++;
    if (bus.out_quotient !== 4'hF || bus.out_remainder !== 4'd9 || bus.out_dbz !== 1'b1 || bus.out_timeout !== 1'b0) begin
      bad++;
      $display("FAIL dbz_result: q=%h r=%0d dbz=%b to=%b required f 9 1 0",
               bus.out_quotient, bus.out_remainder, bus.out_dbz, bus.out_timeout);
    end
    consume;
    tick;
    total++;
    if (starts_seen - s0 !== 0) begin
      bad++;
      $display("FAIL dbz_no_start: %0d pulses required 0", starts_seen - s0);
    end
`else
    total++;
    if (bus.div_start !== 1'b1 || bus.out_dbz !== 1'b0) begin
      bad++;
      $display("FAIL dbz_forward: start=%b dbz=%b required 1 0", bus.div_start, bus.out_dbz);
    end
    wait_valid(40, n);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_dbz !== 1'b0 || starts_seen - s0 !== 1) begin
      bad++;
      $display("FAIL dbz_core_result: vld=%b dbz=%b starts=%0d required 1 0 1",
               bus.out_valid, bus.out_dbz, starts_seen - s0);
    end
    consume;
`endif
  endtask

  task automatic test_reset_mid_busy;
    int n;
    send(4'd15, 4'd3);
    tick;
    tick;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready, bus.div_start, bus.out_valid, bus.out_dbz, bus.out_timeout} !== 5'b10000 ||
        {bus.div_dividend, bus.div_divisor, bus.out_quotient, bus.out_remainder} !== 16'h0000) begin
      bad++;
      $display("FAIL midbusy_reset: ctrl=%b data=%h required 10000 0000",
               {bus.in_ready, bus.div_start, bus.out_valid, bus.out_dbz, bus.out_timeout},
               {bus.div_dividend, bus.div_divisor, bus.out_quotient, bus.out_remainder});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    send(4'd6, 4'd2);
    wait_valid(40, n);
    total++;
    if (n !== 5 || bus.out_quotient !== 4'd3 || bus.out_remainder !== 4'd0 || bus.out_timeout !== 1'b0) begin
      bad++;
      $display("FAIL midbusy_after: n=%0d q=%0d r=%0d to=%b required 5 3 0 0",
               n, bus.out_quotient, bus.out_remainder, bus.out_timeout);
    end
    consume;
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_q [2] = '{4'd3, 4'd1};
    logic [3:0] exp_r [2] = '{4'd1, 4'd0};
    int  idx  = 0;
    int  nacc = 0;
    int  s0   = starts_seen;
    bit  acc;
    bus.out_ready   = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = 4'd10;
    bus.in_divisor  = 4'd3;
    for (int c = 0; c < 80 && idx < 2; c++) begin
      acc = bus.in_valid & bus.in_ready;
      tick;
      if (acc) begin
        nacc++;
        if (nacc == 1) begin
          bus.in_dividend = 4'd8;
          bus.in_divisor  = 4'd8;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        total++;
        if (bus.out_quotient !== exp_q[idx] || bus.out_remainder !== exp_r[idx]) begin
          bad++;
          $display("FAIL b2b_result[%0d]: q=%0d r=%0d required %0d %0d",
                   idx, bus.out_quotient, bus.out_remainder, exp_q[idx], exp_r[idx]);
        end
        idx++;
      end
    end
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    total++;
    if (idx !== 2 || starts_seen - s0 !== 2) begin
      bad++;
      $display("FAIL b2b_count: results=%0d starts=%0d required 2 2", idx, starts_seen - s0);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = 4'd0;
    bus.in_divisor  = 4'd0;
    bus.out_ready   = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_timeout;
    test_done_vs_watchdog;
    test_dbz;
    test_reset_mid_busy;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
